// File: rtl/mem_wb_load_unit.sv
// MEM-stage load unit: issues data-memory reads, aligns/extends the returned word
// and owns the MEM/WB pipeline register feeding write-back and WB forwarding.
module mem_wb_load_unit #(
    parameter int TIMEOUT = 64,
    parameter int RD_AW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      alu_out_MEM,
    input  logic [2:0]       is_load_MEM,
    input  logic [RD_AW-1:0] rd_addr_MEM,
    input  logic             wb_en_MEM,
    input  logic             fwb_en_MEM,
    input  logic             hold_wb,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic [31:0]      dm_req_addr,
    input  logic             dm_rsp_valid,
    input  logic [31:0]      dm_rsp_data,
    input  logic             dm_rsp_err,
    output logic             mem_stall,
    output logic [31:0]      wb_data_WB,
    output logic [RD_AW-1:0] rd_addr_WB,
    output logic             wb_en_WB,
    output logic             fwb_en_WB,
    output logic             load_fault
);

    // state | meaning
    // IDLE  | normal flow; a valid load (and no hold) starts a read
    // REQ   | request presented, waiting for dm_req_ready
    // WAIT  | request accepted, waiting for response or timeout
    // DONE  | response buffered; write back (or fault) once hold_wb drops
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [2:0] LD_LBU = 3'b101;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   rsp_buf;
    logic          err_q;
    logic          req_q;
    logic          load_vld;
    logic          timeout_hit;
    logic          wb_ld_alu, wb_ld_mem, wb_bubble;
    logic [31:0]   rsp_shift;
    logic [31:0]   load_data;

    assign load_vld     = (is_load_MEM != 3'b000) && (is_load_MEM != 3'b111);
    assign timeout_hit  = (wait_cnt == CNT_LAST);
    assign dm_req_valid = req_q;
    assign dm_req_addr  = {alu_out_MEM[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_stall  = 1'b0;
        load_fault = 1'b0;
        wb_ld_alu  = 1'b0;
        wb_ld_mem  = 1'b0;
        wb_bubble  = 1'b0;
        case (state)
            IDLE: begin
                if (!hold_wb) begin
                    if (load_vld) begin
                        mem_stall = 1'b1;
                        wb_bubble = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        wb_ld_alu = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                wb_bubble = 1'b1;
                if (dm_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                mem_stall = 1'b1;
                wb_bubble = 1'b1;
                if (dm_rsp_valid || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                if (!hold_wb) begin
                    wb_ld_mem  = 1'b1;
                    load_fault = err_q;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request valid is a flop so it is clean for the whole REQ state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= 1'b0;
        else     req_q <= (state_nxt == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            rsp_buf  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (dm_rsp_valid) begin
                        rsp_buf <= dm_rsp_data;
                        err_q   <= dm_rsp_err;
                    end else if (timeout_hit) begin
                        rsp_buf <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Misaligned accesses do not split: bytes shifted in from above are zero.
    assign rsp_shift = rsp_buf >> {alu_out_MEM[1:0], 3'b000};

    always_comb begin
        load_data = rsp_shift;
        case (is_load_MEM)
            LD_LH:   load_data = {{16{rsp_shift[15]}}, rsp_shift[15:0]};
            LD_LHU:  load_data = {16'h0000, rsp_shift[15:0]};
            LD_LB:   load_data = {{24{rsp_shift[7]}}, rsp_shift[7:0]};
            LD_LBU:  load_data = {24'h000000, rsp_shift[7:0]};
            default: load_data = rsp_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_WB <= '0;
            rd_addr_WB <= '0;
            wb_en_WB   <= 1'b0;
            fwb_en_WB  <= 1'b0;
        end else if (wb_ld_alu) begin
            wb_data_WB <= alu_out_MEM;
            rd_addr_WB <= rd_addr_MEM;
            wb_en_WB   <= wb_en_MEM;
            fwb_en_WB  <= fwb_en_MEM;
        end else if (wb_ld_mem) begin
            wb_data_WB <= err_q ? 32'h0 : load_data;
            rd_addr_WB <= rd_addr_MEM;
            wb_en_WB   <= wb_en_MEM & ~err_q;
            fwb_en_WB  <= fwb_en_MEM & ~err_q;
        end else if (wb_bubble) begin
            wb_en_WB   <= 1'b0;
            fwb_en_WB  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_load_unit.sv
// Directed bench for mem_wb_load_unit: hand-computed loads, stalls, faults,
// hold_wb freeze and reset mid-transaction.
module tb_mem_wb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_MEM;
    logic [2:0]  is_load_MEM;
    logic [5:0]  rd_addr_MEM;
    logic        wb_en_MEM, fwb_en_MEM, hold_wb;
    logic        dm_req_valid, dm_req_ready;
    logic [31:0] dm_req_addr;
    logic        dm_rsp_valid, dm_rsp_err;
    logic [31:0] dm_rsp_data;
    logic        mem_stall;
    logic [31:0] wb_data_WB;
    logic [5:0]  rd_addr_WB;
    logic        wb_en_WB, fwb_en_WB, load_fault;

    int errors = 0;
    int checks = 0;
    int n_stall, n_req, n_bub, n_fault, n_abad;

    always #5 clk = ~clk;

    mem_wb_load_unit #(.TIMEOUT(8), .RD_AW(6)) dut (
        .clk(clk), .rst(rst),
        .alu_out_MEM(alu_out_MEM), .is_load_MEM(is_load_MEM), .rd_addr_MEM(rd_addr_MEM),
        .wb_en_MEM(wb_en_MEM), .fwb_en_MEM(fwb_en_MEM), .hold_wb(hold_wb),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
        .mem_stall(mem_stall), .wb_data_WB(wb_data_WB), .rd_addr_WB(rd_addr_WB),
        .wb_en_WB(wb_en_WB), .fwb_en_WB(fwb_en_WB), .load_fault(load_fault)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge with the unit in IDLE; returns at the
    // falling edge of the first cycle in which mem_stall is low again (DONE).
    task automatic run_load(input logic [31:0] addr, input logic [2:0] lt, input logic [5:0] rd,
                            input logic [31:0] rsp, input logic err, input int rdy_dly,
                            input int rsp_dly, input bit respond, input bit hold_at_rsp);
        int rdy_cnt, rsp_cnt;
        bit done;
        alu_out_MEM = addr; is_load_MEM = lt; rd_addr_MEM = rd;
        wb_en_MEM = (lt != 3'd6); fwb_en_MEM = (lt == 3'd6); hold_wb = 1'b0;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0; dm_rsp_data = '0;
        n_stall = 0; n_req = 0; n_bub = 0; n_fault = 0; n_abad = 0;
        rdy_cnt = 0; rsp_cnt = -1; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (mem_stall) n_stall++;
            if (c > 0 && mem_stall && (wb_en_WB || fwb_en_WB)) n_bub++;
            if (load_fault) n_fault++;
            if (dm_req_valid) begin
                n_req++;
                if (dm_req_addr !== {addr[31:2], 2'b00}) n_abad++;
            end
            dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0; dm_rsp_data = 32'hDEAD_BEEF;
            if (c > 0 && !mem_stall) begin
                done = 1'b1;
            end else if (dm_req_valid) begin
                if (rdy_cnt == rdy_dly) begin
                    dm_req_ready = 1'b1;
                    rsp_cnt = 0;
                end else begin
                    rdy_cnt++;
                end
            end else if (rsp_cnt >= 0) begin
                if (respond && rsp_cnt == rsp_dly) begin
                    dm_rsp_valid = 1'b1; dm_rsp_data = rsp; dm_rsp_err = err;
                    if (hold_at_rsp) hold_wb = 1'b1;
                    rsp_cnt = -1;
                end else begin
                    rsp_cnt++;
                end
            end
        end
        chk("load_done", 32'(done), 32'd1);
    endtask

    // Let DONE commit, freeze the WB register, and check what it captured.
    task automatic finish_load(input string tag, input logic [31:0] exp_data, input logic [5:0] exp_rd,
                               input logic exp_en, input logic exp_fen);
        @(posedge clk); #1;
        is_load_MEM = 3'b000; hold_wb = 1'b1;
        @(negedge clk);
        chk({tag, "_data"}, wb_data_WB, exp_data);
        chk({tag, "_rd"}, 32'(rd_addr_WB), 32'(exp_rd));
        chk({tag, "_en"}, {30'b0, wb_en_WB, fwb_en_WB}, {30'b0, exp_en, exp_fen});
        chk({tag, "_fault_after"}, 32'(load_fault), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        alu_out_MEM = '0; is_load_MEM = '0; rd_addr_MEM = '0;
        wb_en_MEM = 1'b0; fwb_en_MEM = 1'b0; hold_wb = 1'b0;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0; dm_rsp_data = '0;
        #1;
        chk("rst_wb_data", wb_data_WB, 32'h0);
        chk("rst_outs", {26'b0, dm_req_valid, mem_stall, wb_en_WB, fwb_en_WB, load_fault, |rd_addr_WB}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Plain ALU result through the WB register
        alu_out_MEM = 32'h0000_1234; rd_addr_MEM = 6'd5; wb_en_MEM = 1'b1;
        @(negedge clk);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        finish_load("alu", 32'h0000_1234, 6'd5, 1'b1, 1'b0);

        run_load(32'h0000_0103, 3'b011, 6'd7, 32'h80FF_0000, 1'b0, 0, 0, 1'b1, 1'b0);
        chk("lb_stall_cycles", 32'(n_stall), 32'd3);
        chk("lb_addr", 32'(n_abad), 32'd0);
        finish_load("lb", 32'hFFFF_FF80, 6'd7, 1'b1, 1'b0);

        run_load(32'h0000_0103, 3'b101, 6'd8, 32'h80FF_0000, 1'b0, 0, 0, 1'b1, 1'b0);
        finish_load("lbu", 32'h0000_0080, 6'd8, 1'b1, 1'b0);

        run_load(32'h0000_0002, 3'b010, 6'd9, 32'h8001_7FFF, 1'b0, 0, 0, 1'b1, 1'b0);
        finish_load("lh", 32'hFFFF_8001, 6'd9, 1'b1, 1'b0);

        run_load(32'h0000_0002, 3'b100, 6'd10, 32'h8001_7FFF, 1'b0, 0, 0, 1'b1, 1'b0);
        finish_load("lhu", 32'h0000_8001, 6'd10, 1'b1, 1'b0);

        run_load(32'h0000_0001, 3'b001, 6'd11, 32'hAABB_CCDD, 1'b0, 0, 0, 1'b1, 1'b0);
        finish_load("lw_mis", 32'h00AA_BBCC, 6'd11, 1'b1, 1'b0);

        run_load(32'h0000_0300, 3'b110, 6'h21, 32'h3F80_0000, 1'b0, 0, 0, 1'b1, 1'b0);
        finish_load("flw", 32'h3F80_0000, 6'h21, 1'b0, 1'b1);

        // Slow memory: ready after 5 low cycles, response 4 cycles into WAIT
        run_load(32'h0000_0040, 3'b001, 6'd12, 32'h1234_5678, 1'b0, 5, 4, 1'b1, 1'b0);
        chk("slow_stall_cycles", 32'(n_stall), 32'd12);
        chk("slow_req_cycles", 32'(n_req), 32'd6);
        chk("slow_addr", 32'(n_abad), 32'd0);
        chk("slow_bubble_wr", 32'(n_bub), 32'd0);
        finish_load("slow", 32'h1234_5678, 6'd12, 1'b1, 1'b0);

        // Timeout after 8 WAIT cycles
        run_load(32'h0000_0020, 3'b001, 6'd13, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("to_stall_cycles", 32'(n_stall), 32'd10);
        chk("to_fault", 32'(n_fault), 32'd1);
        finish_load("to", 32'h0, 6'd13, 1'b0, 1'b0);

        run_load(32'h0000_0010, 3'b001, 6'd14, 32'h5555_5555, 1'b1, 0, 0, 1'b1, 1'b0);
        chk("err_stall_cycles", 32'(n_stall), 32'd3);
        chk("err_fault", 32'(n_fault), 32'd1);
        finish_load("err", 32'h0, 6'd14, 1'b0, 1'b0);

        // hold_wb in DONE for 3 cycles, then release
        wb_en_MEM = 1'b1; rd_addr_MEM = 6'd2; alu_out_MEM = 32'h0000_0777;
        hold_wb = 1'b0;
        finish_load("pre_hold", 32'h0000_0777, 6'd2, 1'b1, 1'b0);
        run_load(32'h0000_0021, 3'b101, 6'd15, 32'h0000_A500, 1'b1, 0, 0, 1'b1, 1'b1);
        chk("hold_fault_done", 32'(n_fault), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_data", wb_data_WB, 32'h0000_0777);
            chk("hold_en_fault", {30'b0, wb_en_WB, load_fault}, 32'h0);
        end
        hold_wb = 1'b0;
        #1 chk("hold_release_fault", 32'(load_fault), 32'd1);
        finish_load("hold", 32'h0, 6'd15, 1'b0, 1'b0);

        run_load(32'h0000_0021, 3'b101, 6'd16, 32'h0000_A500, 1'b0, 0, 0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold2_en", {30'b0, wb_en_WB, load_fault}, 32'h0);
        hold_wb = 1'b0;
        finish_load("hold2", 32'h0000_00A5, 6'd16, 1'b1, 1'b0);

        // Reset while in WAIT, then a late response
        alu_out_MEM = 32'h0000_0080; is_load_MEM = 3'b001; rd_addr_MEM = 6'd17; hold_wb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rw_req", 32'(dm_req_valid), 32'd1);
        dm_req_ready = 1'b1;
        @(negedge clk);
        dm_req_ready = 1'b0;
        chk("rw_in_wait", {30'b0, mem_stall, dm_req_valid}, 32'h2);
        #2 rst = 1'b1; is_load_MEM = 3'b000; hold_wb = 1'b1;
        #1;
        chk("rw_rst_outs", {27'b0, dm_req_valid, mem_stall, wb_en_WB, fwb_en_WB, load_fault}, 32'h0);
        chk("rw_rst_data", wb_data_WB, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        dm_rsp_valid = 1'b1; dm_rsp_err = 1'b1; dm_rsp_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dm_rsp_valid = 1'b0; dm_rsp_err = 1'b0;
        chk("late_rsp_outs", {27'b0, dm_req_valid, mem_stall, wb_en_WB, fwb_en_WB, load_fault}, 32'h0);
        chk("late_rsp_data", wb_data_WB, 32'h0);
        @(negedge clk);
        chk("late_rsp_fault", 32'(load_fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_load_unit.md
Name: mem_wb_load_unit

Overview:
- Read-side counterpart of the EX/MEM store path: issues data-memory reads for loads sitting in the MEM stage, then aligns and sign/zero-extends the returned word by address offset and load type.
- Holds the MEM/WB pipeline register that feeds register-file write-back and the WB forwarding path.
- Stalls the upstream pipeline while a read is outstanding; detects bus errors and timeouts.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before a fault is declared (≥2).
- RD_AW, 6: destination register address width (bit 5 selects the FP register file).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_out_MEM  in  32  effective address for loads; result data otherwise
- is_load_MEM  in  3  000 none, 001 LW, 010 LH, 011 LB, 100 LHU, 101 LBU, 110 FLW, 111 treated as none
- rd_addr_MEM  in  RD_AW  destination register
- wb_en_MEM  in  1  integer write-back enable
- fwb_en_MEM  in  1  FP write-back enable
- hold_wb  in  1  external freeze (fetch-side bus stall)
- dm_req_valid  out  1  read request valid
- dm_req_ready  in  1  memory accepts request
- dm_req_addr  out  32  {alu_out_MEM[31:2],2'b00}
- dm_rsp_valid  in  1  read data valid
- dm_rsp_data  in  32  read word
- dm_rsp_err  in  1  bus error, qualified by dm_rsp_valid
- mem_stall  out  1  freeze MEM and earlier stages
- wb_data_WB  out  32  write-back data, also WB forward value
- rd_addr_WB  out  RD_AW
- wb_en_WB  out  1
- fwb_en_WB  out  1
- load_fault  out  1  one-cycle pulse on error or timeout

Behaviour:
- Reset: state IDLE; dm_req_valid=0, mem_stall=0, wb_data_WB=0, rd_addr_WB=0, wb_en_WB=0, fwb_en_WB=0, load_fault=0, wait counter=0, response buffer=0.
- FSM states: IDLE, REQ, WAIT, DONE. Only IDLE and DONE exit toward normal flow.
- IDLE:
  - Load valid (is_load_MEM in 001..110) and !hold_wb: mem_stall=1 combinationally; next state REQ.
  - Otherwise mem_stall=0. If !hold_wb, the WB register loads alu_out_MEM, rd_addr, wb_en and fwb_en. If hold_wb, all WB outputs hold.
- REQ:
  - dm_req_valid=1 (registered, high for the whole state); address stable; mem_stall=1.
  - On dm_req_ready → WAIT, counter cleared.
  - No timeout applies in REQ.
- WAIT:
  - mem_stall=1; counter increments each cycle.
  - dm_rsp_valid → capture data into the buffer, flag error if dm_rsp_err; → DONE.
  - Counter reaching TIMEOUT-1 without a response → flag error, buffer=0; → DONE.
  - dm_rsp_valid takes priority over timeout in the same cycle.
- During REQ/WAIT the WB register takes a bubble: wb_en_WB=0, fwb_en_WB=0; data and rd_addr hold.
- DONE:
  - mem_stall=0.
  - If !hold_wb: WB register loads the aligned data, rd_addr_MEM and the enables. On error, data=0 and both enables=0. load_fault=1 for exactly this cycle. → IDLE.
  - If hold_wb: stay in DONE with no load and no fault pulse.
- Alignment: off=alu_out_MEM[1:0]; s=dm_rsp_data >> (8*off), zero-filled.
  - LW/FLW → s.
  - LH → sext(s[15:0]); LHU → zext(s[15:0]).
  - LB → sext(s[7:0]); LBU → zext(s[7:0]).
  - Misaligned LW/LH do not split: missing upper bytes read as 0 before extension.
- Fault: a faulting load is not retried; the pipeline resumes. Exception handling is outside this block.
- Response arriving in IDLE/REQ/DONE: ignored.
- Reset mid-transaction: immediate return to IDLE with dm_req_valid=0; a late response is ignored per the rule above.
- Latency: with ready and response each in the first possible cycle, a load occupies 4 cycles (IDLE, REQ, WAIT, DONE). mem_stall is high 3 cycles; WB data is visible the cycle after DONE.

Test Plan:
- Non-load ALU result: alu_out_MEM=0x1234, wb_en_MEM=1, rd=5 → next cycle wb_data_WB=0x1234, rd_addr_WB=5, wb_en_WB=1; mem_stall never high.
- LB at addr 0x103, rsp 0x80FF_0000, ready/rsp immediate → mem_stall high 3 cycles, dm_req_addr=0x100, wb_data_WB=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH at addr 0x2, rsp 0x8001_7FFF → 0xFFFF_8001; LHU → 0x0000_8001; LW at offset 1, rsp 0xAABB_CCDD → 0x00AA_BBCC.
- dm_req_ready held low 5 cycles, then rsp 4 cycles later → stays in REQ, dm_req_valid and address stable, mem_stall continuous; correct data written once, no bubble writes.
- No response, TIMEOUT=8 → after 8 WAIT cycles load_fault pulses 1 cycle, wb_en_WB=0; dm_rsp_err=1 response → same fault behaviour.
- hold_wb=1 during DONE for 3 cycles → WB outputs hold, no fault pulse; on release the data loads once. rst asserted in WAIT → outputs reset immediately; a following dm_rsp_valid has no effect.
